// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
//   DATA_BITS      : payload bits per frame (8N1 framing)
//   DEFAULT_BAUDS  : default clk cycles per bit period
//   DEFAULT_DEPTH  : default transmit FIFO depth in bytes
//   tx_state_e     : transmitter FSM state encoding
package uart_pkg;

    localparam int DATA_BITS     = 8;
    localparam int DEFAULT_BAUDS = 104;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- synchronous single-clock byte FIFO feeding the transmitter.
//   clk, rst   : clock and synchronous active-high reset
//   wr_i       : write request; accepted only while not full
//   wr_data_i  : byte to store
//   rd_i       : pop request; honoured only while not empty
//   rd_data_o  : head-of-queue byte (valid while not empty)
//   full_o     : registered, count == DEPTH after the current edge
//   empty_o    : registered, count == 0 after the current edge
//   count_o    : number of stored bytes
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic                 rd_i,
    output logic [DATA_BITS-1:0] rd_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CW-1:0]        count_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_q, empty_q;
    logic                 wr_acc_s, rd_acc_s;

    // Accept/pop qualification and next-state pointers and count.
    // A write while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        wr_acc_s = wr_i && !full_q;
        rd_acc_s = rd_i && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and flag registers; flags follow the post-edge count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            empty_q  <= (count_d == '0);
        end
    end

    // Storage array; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- FIFO-buffered 8N1 UART transmitter.
//   clk      : sole clock
//   rst      : synchronous active-high reset; aborts any frame, flushes FIFO
//   I_DATA   : byte to enqueue
//   WR       : write strobe, one byte per cycle while not full
//   Tx       : serial line, idle high, driven from a flop
//   clk_Tx   : one-cycle tick on the last cycle of every bit period
//   Tx_FULL  : FIFO holds DEPTH bytes
//   Tx_EMPTY : FIFO holds no bytes (shift register not counted)
//   Tx_BUSY  : a frame is in progress
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUDS = DEFAULT_BAUDS,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] I_DATA,
    input  logic                 WR,
    output logic                 Tx,
    output logic                 clk_Tx,
    output logic                 Tx_FULL,
    output logic                 Tx_EMPTY,
    output logic                 Tx_BUSY
);

    localparam int BW = $clog2(BAUDS);
    localparam int IW = $clog2(DATA_BITS);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [BW-1:0] BAUD_LAST   = BW'(BAUDS - 1);
    localparam logic [BW-1:0] BAUD_PENULT = BW'(BAUDS - 2);
    localparam logic [IW-1:0] LAST_BIT    = IW'(DATA_BITS - 1);

    tx_state_e            state_q;
    logic [BW-1:0]        baud_cnt_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q, clk_tx_q, busy_q;

    logic [DATA_BITS-1:0] fifo_rdata_s;
    logic [CW-1:0]        fifo_count_s;
    logic                 fifo_full_s, fifo_empty_s;
    logic                 have_byte_s, baud_end_s, pop_s;

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (WR),
        .wr_data_i (I_DATA),
        .rd_i      (pop_s),
        .rd_data_o (fifo_rdata_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .count_o   (fifo_count_s)
    );

    assign have_byte_s = (fifo_count_s != '0);
    assign baud_end_s  = (baud_cnt_q == BAUD_LAST);

    // Pop the FIFO head when leaving IDLE or chaining straight from STOP.
    always_comb begin
        pop_s = 1'b0;
        case (state_q)
            ST_IDLE: pop_s = have_byte_s;
            ST_STOP: pop_s = baud_end_s && have_byte_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Transmit FSM with registered line, tick and busy outputs.
    // clk_tx_q is set one cycle ahead so it is high exactly while the
    // counter sits at BAUDS-1 in a non-IDLE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            clk_tx_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_cnt_q <= '0;
                    bit_idx_q  <= '0;
                    clk_tx_q   <= 1'b0;
                    if (have_byte_s) begin
                        state_q <= ST_START;
                        shift_q <= fifo_rdata_s;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        state_q    <= ST_DATA;
                        baud_cnt_q <= '0;
                        tx_q       <= shift_q[0];
                        clk_tx_q   <= 1'b0;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                        clk_tx_q   <= (baud_cnt_q == BAUD_PENULT);
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_q <= '0;
                        clk_tx_q   <= 1'b0;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + IW'(1);
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                        clk_tx_q   <= (baud_cnt_q == BAUD_PENULT);
                    end
                end
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        clk_tx_q   <= 1'b0;
                        if (have_byte_s) begin
                            state_q <= ST_START;
                            shift_q <= fifo_rdata_s;
                            tx_q    <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                        clk_tx_q   <= (baud_cnt_q == BAUD_PENULT);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    baud_cnt_q <= '0;
                    bit_idx_q  <= '0;
                    tx_q       <= 1'b1;
                    clk_tx_q   <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign Tx       = tx_q;
    assign clk_Tx   = clk_tx_q;
    assign Tx_BUSY  = busy_q;
    assign Tx_FULL  = fifo_full_s;
    assign Tx_EMPTY = fifo_empty_s;

endmodule
